// File: rtl/cell_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell_test_pkg
// Description : Shared types, constants and Gray helper for the cell sequencer
// Revision    : 1.0
// ============================================================================
package cell_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  localparam int unsigned N_IN_DEF     = 5;
  localparam int unsigned NVEC         = 2**N_IN_DEF;
  localparam logic [31:0] AOI221_TRUTH = 32'h0000_0777;

  function automatic logic [31:0] gray(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_stim_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cell_stim_sequencer_if
// Description : Run-control, cell pin and result bundle of the cell sequencer
// Revision    : 1.0
// ============================================================================
interface cell_stim_sequencer_if #(
  parameter int unsigned N_IN = 5
);
  logic            start;
  logic            abort;
  logic            resp;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN:0]   tog_cnt;
  logic            fail_vld;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, abort, resp,
    output stim, busy, done, pass, err_cnt, tog_cnt, fail_vld, fail_vec
  );

  modport slave (
    output start, abort, resp,
    input  stim, busy, done, pass, err_cnt, tog_cnt, fail_vld, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/cell_sample_check.sv
`default_nettype none
// ============================================================================
// Module      : cell_sample_check
// Description : Per-sample compare, toggle count, mismatch count, first-fail latch
// Revision    : 1.0
// ============================================================================
module cell_sample_check
  import cell_test_pkg::*;
#(
  parameter int unsigned           N_IN  = 5,
  parameter logic [2**N_IN-1:0]    TRUTH = AOI221_TRUTH
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            clr_i,
  input  wire logic            smp_en_i,
  input  wire logic            first_i,
  input  wire logic            resp_i,
  input  wire logic [N_IN-1:0] stim_i,
  output logic [N_IN:0]        err_cnt_o,
  output logic [N_IN:0]        tog_cnt_o,
  output logic                 fail_vld_o,
  output logic [N_IN-1:0]      fail_vec_o
);

  logic [N_IN:0]   err_q, err_d, tog_q, tog_d;
  logic            fvld_q, fvld_d, prev_q, prev_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            w_mis;

  assign w_mis = resp_i ^ TRUTH[stim_i];

  always_comb begin
    err_d  = err_q;
    tog_d  = tog_q;
    fvld_d = fvld_q;
    fvec_d = fvec_q;
    prev_d = prev_q;
    if (clr_i) begin
      err_d  = '0;
      tog_d  = '0;
      fvld_d = 1'b0;
      fvec_d = '0;
    end else if (smp_en_i) begin
      if (w_mis) begin
        err_d = err_q + (N_IN+1)'(1);
        if (!fvld_q) begin
          fvld_d = 1'b1;
          fvec_d = stim_i;
        end
      end
      // The first sample of a run has no predecessor to toggle against
      if (!first_i && (resp_i != prev_q)) tog_d = tog_q + (N_IN+1)'(1);
      prev_d = resp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      tog_q  <= '0;
      fvld_q <= 1'b0;
      fvec_q <= '0;
      prev_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      tog_q  <= tog_d;
      fvld_q <= fvld_d;
      fvec_q <= fvec_d;
      prev_q <= prev_d;
    end
  end

  assign err_cnt_o  = err_q;
  assign tog_cnt_o  = tog_q;
  assign fail_vld_o = fvld_q;
  assign fail_vec_o = fvec_q;

endmodule
`default_nettype wire

// File: rtl/cell_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cell_stim_sequencer
// Description : Gray-order stimulus walk with settle/sample FSM for one cell
// Revision    : 1.0
// ============================================================================
module cell_stim_sequencer
  import cell_test_pkg::*;
#(
  parameter int unsigned        N_IN   = 5,
  parameter int unsigned        SETTLE = 4,
  parameter logic [2**N_IN-1:0] TRUTH  = AOI221_TRUTH
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  cell_stim_sequencer_if.master  seq_if
);

  localparam int unsigned     WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0]   WAIT_INIT = WW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d, stim_q, stim_d, w_idx_nxt;
  logic [WW-1:0]   wait_q, wait_d;
  logic            pass_q, pass_d;
  logic            w_busy, w_done, w_run_start, w_smp_en;
  logic [N_IN:0]   w_err_cnt, w_tog_cnt;
  logic            w_fail_vld;
  logic [N_IN-1:0] w_fail_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seq_if.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (seq_if.start) state_d = ST_HOLD;
        ST_HOLD:   if (wait_q == '0) state_d = ST_SAMPLE;
        ST_SAMPLE: state_d = (idx_q == IDX_LAST) ? ST_FIN : ST_HOLD;
        ST_FIN:    state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy      = (state_q != ST_IDLE);
    w_done      = (state_q == ST_FIN) && !seq_if.abort;
    w_run_start = (state_q == ST_IDLE) && seq_if.start && !seq_if.abort;
    w_smp_en    = (state_q == ST_SAMPLE) && !seq_if.abort;
  end

  assign w_idx_nxt = idx_q + N_IN'(1);

  always_comb begin
    idx_d  = idx_q;
    wait_d = wait_q;
    stim_d = stim_q;
    pass_d = pass_q;
    if (seq_if.abort) begin
      stim_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq_if.start) begin
            idx_d  = '0;
            stim_d = '0;
            wait_d = WAIT_INIT;
          end
        end
        ST_HOLD: begin
          if (wait_q != '0) wait_d = wait_q - WW'(1);
        end
        ST_SAMPLE: begin
          if (idx_q != IDX_LAST) begin
            idx_d  = w_idx_nxt;
            stim_d = N_IN'(gray(32'(w_idx_nxt)));
            wait_d = WAIT_INIT;
          end
        end
        ST_FIN: begin
          pass_d = (w_err_cnt == '0);
          stim_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wait_q <= '0;
      stim_q <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wait_q <= wait_d;
      stim_q <= stim_d;
      pass_q <= pass_d;
    end
  end

  cell_sample_check #(
    .N_IN  (N_IN),
    .TRUTH (TRUTH)
  ) u_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (w_run_start),
    .smp_en_i   (w_smp_en),
    .first_i    (idx_q == '0),
    .resp_i     (seq_if.resp),
    .stim_i     (stim_q),
    .err_cnt_o  (w_err_cnt),
    .tog_cnt_o  (w_tog_cnt),
    .fail_vld_o (w_fail_vld),
    .fail_vec_o (w_fail_vec)
  );

  assign seq_if.stim     = stim_q;
  assign seq_if.busy     = w_busy;
  assign seq_if.done     = w_done;
  assign seq_if.pass     = pass_q;
  assign seq_if.err_cnt  = w_err_cnt;
  assign seq_if.tog_cnt  = w_tog_cnt;
  assign seq_if.fail_vld = w_fail_vld;
  assign seq_if.fail_vec = w_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_cell_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_stim_sequencer
// Description : Directed, table-driven bench for cell_stim_sequencer (AOI221)
// Revision    : 1.0
// ============================================================================
module tb_cell_stim_sequencer;
  import cell_test_pkg::*;

  localparam int N = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_stim_sequencer_if #(.N_IN(N)) bus_if();

  int   resp_mode = 0;   // 0 golden, 1 tied low, 2 inverted golden
  logic golden;
  assign golden = ~((bus_if.stim[0] & bus_if.stim[1]) |
                    (bus_if.stim[2] & bus_if.stim[3]) | bus_if.stim[4]);
  assign bus_if.resp = (resp_mode == 0) ? golden :
                       (resp_mode == 1) ? 1'b0 : ~golden;

  cell_stim_sequencer #(
    .N_IN   (N),
    .SETTLE (4),
    .TRUTH  (32'h0000_0777)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus_if.master)
  );

  typedef struct {
    int mode;
    int exp_err;
    int exp_tog;
    int exp_fvld;
    int exp_fvec;
    int exp_pass;
  } vec_t;

  vec_t vecs[3];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Records every distinct STIM value seen while BUSY
  int   seq[$];
  logic prev_busy = 1'b0;
  int   prev_stim = 0;
  always @(posedge clk) begin
    #1;
    if (bus_if.busy) begin
      if (!prev_busy || (int'(bus_if.stim) != prev_stim)) seq.push_back(int'(bus_if.stim));
    end
    prev_busy = bus_if.busy;
    prev_stim = int'(bus_if.stim);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     int'(bus_if.busy),     0);
    chk({tag, "_done"},     int'(bus_if.done),     0);
    chk({tag, "_pass"},     int'(bus_if.pass),     0);
    chk({tag, "_stim"},     int'(bus_if.stim),     0);
    chk({tag, "_err"},      int'(bus_if.err_cnt),  0);
    chk({tag, "_tog"},      int'(bus_if.tog_cnt),  0);
    chk({tag, "_fail_vld"}, int'(bus_if.fail_vld), 0);
    chk({tag, "_fail_vec"}, int'(bus_if.fail_vec), 0);
  endtask

  task automatic start_run();
    seq.delete();
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad_order, bad_ham, done_seen;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;

    vecs[0] = '{mode: 1, exp_err: 9,  exp_tog: 0, exp_fvld: 1, exp_fvec: 0, exp_pass: 0};
    vecs[1] = '{mode: 2, exp_err: 32, exp_tog: 9, exp_fvld: 1, exp_fvec: 0, exp_pass: 0};
    vecs[2] = '{mode: 0, exp_err: 0,  exp_tog: 9, exp_fvld: 0, exp_fvec: 0, exp_pass: 1};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // START and ABORT together in IDLE: must not start
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    chk("start_abort_idle_busy", int'(bus_if.busy), 0);
    @(posedge clk); #1;
    chk("start_abort_idle_busy2", int'(bus_if.busy), 0);

    // Full runs, issued back to back (next START in the IDLE cycle after FIN)
    for (int i = 0; i < 3; i++) begin
      resp_mode = vecs[i].mode;
      start_run();
      cyc = 1;
      while (!bus_if.done && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("run%0d_done_cycle", i), cyc, 161);
      chk($sformatf("run%0d_busy_in_fin", i), int'(bus_if.busy), 1);
      chk($sformatf("run%0d_stim_in_fin", i), int'(bus_if.stim), 16);
      @(posedge clk); #1;
      chk($sformatf("run%0d_done_pulse", i), int'(bus_if.done), 0);
      chk($sformatf("run%0d_busy_after", i), int'(bus_if.busy), 0);
      chk($sformatf("run%0d_stim_after", i), int'(bus_if.stim), 0);
      chk($sformatf("run%0d_pass", i), int'(bus_if.pass), vecs[i].exp_pass);
      chk($sformatf("run%0d_err", i), int'(bus_if.err_cnt), vecs[i].exp_err);
      chk($sformatf("run%0d_tog", i), int'(bus_if.tog_cnt), vecs[i].exp_tog);
      chk($sformatf("run%0d_fail_vld", i), int'(bus_if.fail_vld), vecs[i].exp_fvld);
      chk($sformatf("run%0d_fail_vec", i), int'(bus_if.fail_vec), vecs[i].exp_fvec);

      bad_order = 0;
      bad_ham   = 0;
      for (int k = 0; k < seq.size(); k++) begin
        if (seq[k] != (k ^ (k >> 1))) bad_order++;
        if (k > 0 && $countones(seq[k] ^ seq[k-1]) != 1) bad_ham++;
      end
      chk($sformatf("run%0d_seq_len", i), seq.size(), NVEC);
      chk($sformatf("run%0d_seq_order_errs", i), bad_order, 0);
      chk($sformatf("run%0d_seq_hamming_errs", i), bad_ham, 0);
    end

    // ABORT at cycle 50 of a golden run; PASS from the previous run is 1
    resp_mode = 0;
    start_run();
    cyc = 1;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    chk("abort_busy", int'(bus_if.busy), 0);
    chk("abort_stim", int'(bus_if.stim), 0);
    chk("abort_done", int'(bus_if.done), 0);
    chk("abort_pass_kept", int'(bus_if.pass), 1);
    chk("abort_tog_partial", int'(bus_if.tog_cnt), 5);
    done_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_if.done || bus_if.busy) done_seen++;
    end
    chk("abort_no_done_or_busy", done_seen, 0);
    chk("abort_tog_frozen", int'(bus_if.tog_cnt), 5);

    // START pulses mid-run are ignored; async reset mid-run clears everything
    resp_mode = 1;
    start_run();
    cyc = 1;
    while (cyc < 99) begin
      bus_if.start = (cyc == 10 || cyc == 80);
      @(posedge clk); #1;
      cyc++;
    end
    bus_if.start = 1'b0;
    chk("restart_ignored_stim", int'(bus_if.stim), 26);
    chk("restart_ignored_err", int'(bus_if.err_cnt), 9);
    chk("restart_ignored_busy", int'(bus_if.busy), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", int'(bus_if.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cell_stim_sequencer.md
# cell_stim_sequencer

Self-checking stimulus controller for one combinational standard cell under test, default the 5-input AOI221 (QN = ~((IN1&IN2)|(IN3&IN4)|IN5)). On START it walks every input vector in Gray-code order, so exactly one cell input toggles per step. It holds each vector for a programmable settle time, samples the cell output and compares it against a truth-table constant. It also counts output toggles for power-characterisation runs. It sits in the cell test harness between the run-control logic and the cell's input pins.

## Interface
- N_IN, 5, number of cell inputs; STIM[0] drives IN1 … STIM[N_IN-1] drives INn
- SETTLE, 4, hold cycles per vector before the sample cycle; must be ≥1
- TRUTH, 32'h0000_0777, expected output; bit i = cell output for STIM == i
- CLK  in  1  rising-edge clock
- RSTB  in  1  asynchronous active-low reset
- START  in  1  begin a run; sampled only in IDLE
- ABORT  in  1  synchronous abort; priority over all but reset
- RESP  in  1  cell output (QN), combinationally derived from STIM
- STIM  out  N_IN  registered cell input vector
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse after the last sample
- PASS  out  1  last completed run had zero mismatches
- ERR_CNT  out  N_IN+1  mismatch count of the current or last run
- TOG_CNT  out  N_IN+1  RESP transitions between consecutive samples
- FAIL_VLD  out  1  at least one mismatch seen in the run
- FAIL_VEC  out  N_IN  STIM value at the first mismatch

## Operation
- States: IDLE, HOLD, SAMPLE, FIN.
- IDLE, START=1:
  - idx←0, STIM←0, ERR_CNT←0, TOG_CNT←0, FAIL_VLD←0, FAIL_VEC←0, wait←SETTLE-1.
  - Go to HOLD.
- HOLD: if wait==0, go to SAMPLE; otherwise wait decrements.
- SAMPLE:
  - mis = RESP ^ TRUTH[STIM].
  - If mis: ERR_CNT++. If FAIL_VLD==0, latch FAIL_VEC←STIM and set FAIL_VLD←1.
  - If idx≠0 and RESP≠prev: TOG_CNT++. Then prev←RESP.
  - If idx==2^N_IN-1, go to FIN.
  - Otherwise idx++, STIM←idx_next^(idx_next>>1), wait←SETTLE-1, go to HOLD.
- FIN: DONE=1 and PASS←(ERR_CNT==0). BUSY falls on the following edge. STIM←0. Go to IDLE.
- Counter widths: N_IN+1 bits hold 2^N_IN, so neither counter can overflow and no saturation logic is needed.
- START while BUSY: ignored.
- START and ABORT high together in IDLE: ABORT wins and the run does not start.
- ABORT in any non-IDLE state: next state IDLE, STIM←0, no DONE. PASS keeps its previous value. ERR_CNT, TOG_CNT and FAIL_* freeze at their partial values.
- Reset values: state IDLE; STIM, BUSY, DONE, PASS, counters, FAIL_VLD and FAIL_VEC all 0.

## Timing
- STIM changes only at the edge that enters HOLD.
- Each vector is stable for SETTLE+1 cycles. RESP is sampled at the edge that leaves SAMPLE. No synchroniser is used, because RESP settles inside the hold window.
- BUSY=1 from the edge that accepts START until the edge that leaves FIN.
- Full run: the START edge plus 2^N_IN·(SETTLE+1) cycles, then a one-cycle FIN. Defaults: 160 cycles, DONE high in cycle 161.
- Back-to-back runs: START may be high in the cycle after FIN. There is one IDLE cycle minimum between runs.
- RSTB low mid-run: all outputs go to their reset values immediately, independent of the clock.

## Structure
- Package cell_test_pkg holds:
  - the state enum;
  - the gray() function;
  - the AOI221 truth constant 32'h0000_0777;
  - localparam NVEC = 2**N_IN.
- One natural sub-module, cell_sample_check: mismatch compare, toggle detect, both counters and the first-fail latch. The top level keeps the FSM, idx/wait counters and STIM register.

## Test plan
- Golden AOI221 model on RESP, defaults → DONE in cycle 161, PASS=1, ERR_CNT=0, TOG_CNT=9, FAIL_VLD=0.
- RESP tied 0 → ERR_CNT=9, TOG_CNT=0, FAIL_VEC=0, FAIL_VLD=1, PASS=0.
- RESP = ~golden → ERR_CNT=32, FAIL_VEC=0, PASS=0, TOG_CNT=9.
- ABORT at cycle 50 → BUSY=0 the next cycle, STIM=0, no DONE pulse, PASS unchanged from the prior run.
- START pulsed at cycles 10 and 80 of a run, then RSTB low at cycle 100 → no restart from either pulse; after reset, all outputs are 0.
- Check STIM against the previous step on every HOLD entry → Hamming distance is exactly 1. Sequence runs 0,1,3,2,6,… and ends at 16.
